uart_alu_ctrl: RTL

//   Sequencer between the UART receiver, the ALU and the UART transmitter.
//   - Collects three received bytes in order: operand A, operand B, opcode.
//   - Presents them to the ALU, captures the ALU result and starts one transmit.
//   - Waits for transmit completion, then accepts the next command.

---
 rtl/uart_alu_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl - sequencer between a UART receiver, an ALU and a UART transmitter.
//
// Purpose:
//   Collects three received bytes (operand A, operand B, opcode), presents them
//   to a combinational ALU, captures the result one cycle later and issues a
//   single transmit start. Then waits for the transmitter to finish before the
//   next command is accepted.
//
// Ports:
//   clk, i_rst              clock; synchronous active-high reset
//   i_rx_data, i_rx_done    received byte and its 1-cycle valid strobe
//   i_alu_result            combinational ALU result for o_data_a/o_data_b/o_op
//   i_tx_done               1-cycle strobe, transmitter finished its frame
//   o_data_a, o_data_b      registered operands to the ALU
//   o_op                    registered opcode to the ALU (low NB_OP bits of the byte)
//   o_tx_data, o_tx_start   registered byte and 1-cycle start strobe to the transmitter
//   o_busy                  high in EXEC, SEND and WAIT_TX
//   o_overrun               1-cycle pulse, a byte arrived while busy and was dropped
//   o_timeout               1-cycle pulse, a partial command was abandoned
//
// Configuration:
//   Define UART_ALU_CTRL_TIMEOUT_EN to build the inter-byte timeout. Without it,
//   GET_B and GET_OP wait indefinitely and o_timeout is tied low.
//
// Latency: opcode strobe in cycle n -> o_op valid n+1 -> o_tx_start in n+2.
// Flow control: none upstream; bytes arriving while busy are dropped and flagged.

module uart_alu_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int NB_TOUT     = 16,
  parameter int TOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  // One-hot state encoding.
  localparam logic [5:0] ST_GET_A   = 6'b000001;
  localparam logic [5:0] ST_GET_B   = 6'b000010;
  localparam logic [5:0] ST_GET_OP  = 6'b000100;
  localparam logic [5:0] ST_EXEC    = 6'b001000;
  localparam logic [5:0] ST_SEND    = 6'b010000;
  localparam logic [5:0] ST_WAIT_TX = 6'b100000;

  logic [5:0] state;
  logic [5:0] next_state;

  // Decodes of the current state. Full-vector compares so that an illegal
  // encoding matches none of them and therefore raises no strobe.
  logic in_get_a;
  logic in_get_b;
  logic in_get_op;
  logic in_exec;
  logic in_busy;
  logic next_busy;
  logic tout_exp;

  assign in_get_a  = (state == ST_GET_A);
  assign in_get_b  = (state == ST_GET_B);
  assign in_get_op = (state == ST_GET_OP);
  assign in_exec   = (state == ST_EXEC);
  assign in_busy   = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);

  // o_busy is registered from the next state so it lines up with the state
  // register rather than lagging it by a cycle.
  assign next_busy = (next_state == ST_EXEC) || (next_state == ST_SEND) ||
                     (next_state == ST_WAIT_TX);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  // Inter-byte timeout. Counts only while part of a command has been
  // received; any accepted byte restarts the count. A byte arriving in the
  // expiry cycle is accepted instead of timing out.
  logic [NB_TOUT-1:0] tout_cnt;
  logic               timeout_q;
  logic               tout_armed;

  assign tout_armed = in_get_b || in_get_op;
  assign tout_exp   = tout_armed && !i_rx_done &&
                      (tout_cnt == NB_TOUT'(TOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      tout_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (i_rx_done || !tout_armed || tout_exp) begin
        tout_cnt <= '0;
      end else begin
        tout_cnt <= tout_cnt + 1'b1;
      end
      timeout_q <= tout_exp;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Timeout not built: partial commands are held until completed or reset.
  logic [63:0] unused_tout_cfg;

  assign unused_tout_cfg = {NB_TOUT, TOUT_CYCLES};
  assign tout_exp        = 1'b0;
  assign o_timeout       = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    next_state = ST_GET_A;
    case (state)
      ST_GET_A: begin
        next_state = i_rx_done ? ST_GET_B : ST_GET_A;
      end
      ST_GET_B: begin
        if (i_rx_done) begin
          next_state = ST_GET_OP;
        end else if (tout_exp) begin
          next_state = ST_GET_A;
        end else begin
          next_state = ST_GET_B;
        end
      end
      ST_GET_OP: begin
        if (i_rx_done) begin
          next_state = ST_EXEC;
        end else if (tout_exp) begin
          next_state = ST_GET_A;
        end else begin
          next_state = ST_GET_OP;
        end
      end
      // EXEC and SEND are single-cycle states; i_tx_done is ignored in SEND.
      ST_EXEC:    next_state = ST_SEND;
      ST_SEND:    next_state = ST_WAIT_TX;
      // A byte arriving together with i_tx_done is still dropped: the
      // transition to GET_A happens on this edge, but the byte is not operand A.
      ST_WAIT_TX: next_state = i_tx_done ? ST_GET_A : ST_WAIT_TX;
      default:    next_state = ST_GET_A;
    endcase
  end

  // State, datapath and strobes.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= ST_GET_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state <= next_state;

      if (in_get_a && i_rx_done) begin
        o_data_a <= i_rx_data;
      end
      if (in_get_b && i_rx_done) begin
        o_data_b <= i_rx_data;
      end
      if (in_get_op && i_rx_done) begin
        o_op <= i_rx_data[NB_OP-1:0];
      end

      // Operands were registered on entry to EXEC, so the ALU has had a full
      // cycle to settle by the time the result is captured here.
      if (in_exec) begin
        o_tx_data <= i_alu_result;
      end

      o_tx_start <= (next_state == ST_SEND);
      o_busy     <= next_busy;
      o_overrun  <= i_rx_done && in_busy;
    end
  end

endmodule
